// File: rtl/rotary_encoder_bank.sv
// rtl/rotary_encoder_bank.sv - bank of quadrature encoder counters with push-button channel select
//
// One encoder (A/B plus push-button) drives a bank of CH_NUM counters. The
// button steps the active channel (sel). Quadrature steps update only the
// active channel.
//
// Optional input filter: define ROTARY_ENCODER_BANK_FILTER_EN to add a
// FILT_LEN-sample stability filter behind the synchronisers.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   a_pin, b_pin        raw quadrature inputs (idle high)
//   sw_pin              raw push-button (idle high); falling edge advances sel
//   load, load_ch, din  one-cycle load of din into channel load_ch
//   cnt_flat            all counters, channel k at [k*WIDTH +: WIDTH]
//   sel                 active channel index
//   step_vld, step_dir  one-cycle count pulse and its direction (1 = up)
//   err                 one-cycle pulse on an illegal quadrature jump (x4 only)
//   lim                 one-cycle pulse on a wrap or clamp event
module rotary_encoder_bank #(
  parameter int CH_NUM   = 10,
  parameter int WIDTH    = 32,
  parameter int X4_MODE  = 0,
  parameter int SATURATE = 0,
  parameter int FILT_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_pin,
  input  logic                    b_pin,
  input  logic                    sw_pin,
  input  logic                    load,
  input  logic [3:0]              load_ch,
  input  logic [WIDTH-1:0]        din,
  output logic [CH_NUM*WIDTH-1:0] cnt_flat,
  output logic [3:0]              sel,
  output logic                    step_vld,
  output logic                    step_dir,
  output logic                    err,
  output logic                    lim
);

  localparam logic [WIDTH-1:0] ONE = 1;

  // Bit order for all 3-bit pin vectors: {a, b, sw}
  logic [2:0] sync1, sync2, filt, prev;

  // All pre-decode state presets high so the idle-high pins never look like
  // an edge when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {a_pin, b_pin, sw_pin};
      sync2 <= sync1;
    end
  end

`ifdef ROTARY_ENCODER_BANK_FILTER_EN
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  // fcnt counts how long sync2 has disagreed with filt; any agreement
  // restarts the qualification.
  logic [FW-1:0] fcnt [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '1;
      for (int i = 0; i < 3; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '1;
    else     prev <= filt;
  end

  logic a, b, sw;
  assign a  = filt[2];
  assign b  = filt[1];
  assign sw = filt[0];

  // Quadrature decode from previous and current {A,B}
  logic cnt_ev, dir, bad;
  always_comb begin
    cnt_ev = 1'b0;
    dir    = 1'b0;
    bad    = 1'b0;
    if (X4_MODE == 0) begin
      if (prev[2] && !a) begin
        cnt_ev = 1'b1;
        dir    = b;
      end
    end else begin
      case ({prev[2:1], a, b})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
          cnt_ev = 1'b1;
          dir    = 1'b1;
        end
        4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
          cnt_ev = 1'b1;
          dir    = 1'b0;
        end
        // Both lines moved at once: direction unknown, flag and skip
        4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
        default: ;
      endcase
    end
  end

  logic sw_fall;
  assign sw_fall = prev[0] && !sw;

  logic [WIDTH-1:0] cnt [CH_NUM];
  logic [WIDTH-1:0] cur, nxt;
  logic             at_edge, load_ok, drop, take;

  always_comb begin
    cur = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (sel == 4'(k)) cur = cnt[k];
    end
  end

  always_comb begin
    at_edge = dir ? (cur == {WIDTH{1'b1}}) : (cur == '0);
    if ((SATURATE != 0) && at_edge) nxt = cur;
    else if (dir)                   nxt = cur + ONE;
    else                            nxt = cur - ONE;
  end

  // A load to the channel being counted wins; the count is discarded entirely.
  assign load_ok = load && ({1'b0, load_ch} < 5'(CH_NUM));
  assign drop    = load_ok && (load_ch == sel);
  assign take    = cnt_ev && !drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH_NUM; k++) cnt[k] <= '0;
      sel      <= '0;
      step_vld <= 1'b0;
      step_dir <= 1'b0;
      err      <= 1'b0;
      lim      <= 1'b0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (load_ok && (load_ch == 4'(k)))  cnt[k] <= din;
        else if (take && (sel == 4'(k)))    cnt[k] <= nxt;
      end
      step_vld <= take;
      step_dir <= take && dir;
      lim      <= take && at_edge;
      err      <= bad;
      // Counting above uses the old sel, so a same-cycle press affects the next count
      if (sw_fall) sel <= (sel == 4'(CH_NUM - 1)) ? 4'd0 : sel + 4'd1;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_flat
    assign cnt_flat[k*WIDTH +: WIDTH] = cnt[k];
  end

endmodule

// File: doc/rotary_encoder_bank.md
ROTARY_ENCODER_BANK -- requirements
Module: rotary_encoder_bank

Interface
REQ-001 SHALL have parameter CH_NUM, default 10, number of counter channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 32, counter width in bits (8..32).
REQ-003 SHALL have parameter X4_MODE, default 0: 0 = x1 decode, 1 = x4 decode.
REQ-004 SHALL have parameter SATURATE, default 0: 0 = wrap, 1 = clamp.
REQ-005 SHALL have parameter FILT_LEN, default 4, number of stable samples for the input filter.
REQ-006 SHALL have port clk  input  1  system clock; all state is on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports a_pin, b_pin, sw_pin  input  1 each  raw encoder A, B and push-button (idle high).
REQ-009 SHALL have port load  input  1  one-cycle load strobe.
REQ-010 SHALL have port load_ch  input  4  channel index for load.
REQ-011 SHALL have port din  input  WIDTH  load value.
REQ-012 SHALL have port cnt_flat  output  CH_NUM*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port sel  output  4  active channel index.
REQ-014 SHALL have ports step_vld, step_dir  output  1 each  one-cycle count pulse; direction 1 = up.
REQ-015 SHALL have ports err, lim  output  1 each  one-cycle pulses: illegal quadrature transition; wrap or clamp event.

Function
REQ-016 SHALL pass a_pin, b_pin and sw_pin through 2-flop synchronisers before any use.
REQ-017 SHALL, when X4_MODE=0, count on each falling edge of synchronised A: +1 if B=1, -1 if B=0.
REQ-018 SHALL, when X4_MODE=1, count every legal Gray step of {A,B}: 00->01->11->10->00 = +1, reverse = -1.
REQ-019 SHALL, when X4_MODE=1, ignore a simultaneous A and B change (no count), pulse err for one cycle, and adopt the new {A,B} as the reference state.
REQ-020 SHALL, on each falling edge of filtered sw, advance sel by 1 and wrap from CH_NUM-1 to 0; sel never exceeds CH_NUM-1.
REQ-021 SHALL update only the channel addressed by sel on a count; all other channels hold their values.
REQ-022 SHALL raise step_vld and step_dir in the same cycle the counter updates.
REQ-023 SHALL, on load=1 with load_ch<CH_NUM, write din into channel load_ch on the next rising edge.
REQ-024 SHALL ignore load when load_ch>=CH_NUM.
REQ-025 SHALL give load priority when a count and a load target the same channel in the same cycle: din is stored, the count is dropped, and step_vld stays 0.
REQ-026 SHALL, with SATURATE=0, wrap modulo 2^WIDTH (max+1 -> 0, 0-1 -> max) and pulse lim.
REQ-027 SHALL, with SATURATE=1, hold at 0 or 2^WIDTH-1, pulse lim, and still pulse step_vld.
REQ-028 SHALL update the counter exactly 3 clk cycles after the pin edge when filtering is disabled.
REQ-029 SHALL let a channel change on sel take effect for the next count; a count and a sel change in the same cycle apply to the old sel.

Reset
REQ-030 SHALL, on rst, clear all counters, sel, step_vld, step_dir, err and lim to 0.
REQ-031 SHALL preset synchroniser, filter and previous-state registers to 1 (idle high), so that no count or sel advance follows reset release.
REQ-032 SHALL abort any in-progress filter qualification on rst and restart it cleanly after release.

Configuration
REQ-033 SHALL honour macro ROTARY_ENCODER_BANK_FILTER_EN.
REQ-034 SHALL, when ROTARY_ENCODER_BANK_FILTER_EN is defined, change a filtered input only after FILT_LEN consecutive equal synchronised samples; latency becomes 3+FILT_LEN cycles.
REQ-035 SHALL, when ROTARY_ENCODER_BANK_FILTER_EN is undefined, pass the synchronised inputs straight through, with FILT_LEN unused and no filter registers.

Verification
REQ-036 SHALL cover: X4_MODE=0, sel=0, 5 clean CW detents (B=1 at A fall) -> channel 0 = 5, step_vld pulsed 5 times.
REQ-037 SHALL cover: X4_MODE=1, one full CW cycle 00->01->11->10->00 then a full CCW cycle -> count 4 then 0; step_dir 1 then 0.
REQ-038 SHALL cover: X4_MODE=1, jump 00->11 -> err pulses once; counter unchanged.
REQ-039 SHALL cover: CH_NUM=10, 11 sw presses -> sel sequence 1..9, 0, 1; after select of channel 3, counts land only in channel 3.
REQ-040 SHALL cover: WIDTH=8, load 255 into channel 0 then one up-count -> SATURATE=0 gives 0 with lim pulse; SATURATE=1 gives 255 with lim pulse.
REQ-041 SHALL cover: load_ch=sel=2 coincident with a count -> channel 2 = din, step_vld=0; load_ch=12 -> no channel changes.
